// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/fourbitcla_lowprompt.sv
// 4-bit carry-lookahead adder slice: all carries derived directly from generate/propagate.
module fourbitcla_lowprompt (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit add/subtract engine: one 4-bit CLA slice reused per nibble, LSB first,
// with the inter-nibble carry held in carry_q. Valid/ready handshake on both sides.
module cla_nibble_seq
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / CLA_SLICE_W;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % CLA_SLICE_W) != 0 || WIDTH < CLA_SLICE_W) begin : g_bad_width
        $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   carry_q, carry_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;

    int unsigned            nib_base;
    logic [CLA_SLICE_W-1:0] slice_a;
    logic [CLA_SLICE_W-1:0] slice_b;
    logic [CLA_SLICE_W-1:0] slice_sum;
    logic                   slice_cout;
    logic                   last_nib;

    always_comb begin
        nib_base = CLA_SLICE_W * 32'(idx_q);
        slice_a  = a_q[nib_base +: CLA_SLICE_W];
        slice_b  = b_q[nib_base +: CLA_SLICE_W];
        last_nib = (idx_q == IDXW'(NIBBLES - 1));
    end

    fourbitcla_lowprompt u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1, so the +1 rides in as the initial carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[nib_base +: CLA_SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (last_nib) begin
                    state_d = StDone;
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[CLA_SLICE_W-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq: arithmetic reference model plus per-vector literal checks.
module tb_cla_nibble_seq;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic          pending = 1'b0;
    logic [17:0]   exp_res = '0;

    cla_nibble_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        int          sa;
        int          sb;
        int          r;
        logic [16:0] full;
        logic        co;
        logic        ov;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            full = {1'b0, ma} - {1'b0, mb};
            co   = (ma >= mb);
            r    = sa - sb;
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
            co   = full[16];
            r    = sa + sb + int'(mc);
        end
        ov = (r > 32767) || (r < -32768);
        return {co, ov, full[15:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (out_valid && out_ready) pending = 1'b0;
            if (in_valid && in_ready) begin
                exp_res = model(a, b, cin, sub);
                pending = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready && out_valid) chk("ready_valid_exclusive", 32'd1, 32'd0);
            if (out_valid) begin
                chk("cmp_pending", {31'd0, pending}, 32'd1);
                chk("cmp_result", {14'd0, cout, ovf, sum}, {14'd0, exp_res});
            end
        end
    end

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo, input int stall, input bit scramble);
        logic [17:0] m;
        int          edges;
        m = model(ta, tb_, tc, ts);
        chk({nm, "_model"}, {14'd0, m}, {14'd0, ec, eo, es});
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        out_ready = (stall == 0);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        if (scramble) scramble_inputs();
        else in_valid = 1'b0;
        while (!out_valid && edges < 20) begin
            if (scramble) chk({nm, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            edges++;
            if (scramble) scramble_inputs();
        end
        chk({nm, "_latency"}, edges, NIBBLES + 1);
        chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (scramble) scramble_inputs();
            chk({nm, "_hold"}, {14'd0, cout, ovf, sum}, {14'd0, ec, eo, es});
            chk({nm, "_hold_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_outputs", {13'd0, in_ready, out_valid, cout, ovf, sum},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
        do_op("sub_borrow_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
        do_op("stall", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 3, 1'b1);
        do_op("after_stall", 16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 1'b0);

        // Reset during the second RUN cycle, after nibble 0 has been written.
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {13'd0, in_ready, out_valid, cout, ovf, sum},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midreset_no_valid", {30'd0, out_valid, in_ready}, 32'd1);
        end
        do_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
